// File: rtl/adder_pkg.sv
// Shared definitions for the AXI-Stream adder stage.
package adder_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  // Output buffer occupancy; the encoding is the entry count itself.
  typedef enum logic [1:0] {
    CNT_EMPTY = 2'd0,
    CNT_ONE   = 2'd1,
    CNT_FULL  = 2'd2
  } count_e;

  // Sum width: one carry bit above the operand width.
  function automatic int unsigned sum_width(input int unsigned width);
    return width + 1;
  endfunction

endpackage

// File: rtl/adder_comb.sv
// Purely combinational unsigned adder with carry-out as the sum MSB.
module adder_comb
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH:0]   sum
);

  // Zero-extend both operands so the carry lands in the top bit.
  assign sum = {1'b0, op_a} + {1'b0, op_b};

endmodule

// File: rtl/adder_axis.sv
// AXI-Stream stage: joins two operand streams, adds them and buffers the
// sums in a 2-entry FIFO so input readies never see the downstream ready.
module adder_axis
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] data1_tdata_i,
  input  logic             data1_tvalid_i,
  output logic             data1_tready_o,
  input  logic [WIDTH-1:0] data2_tdata_i,
  input  logic             data2_tvalid_i,
  output logic             data2_tready_o,
  output logic [WIDTH:0]   sum_tdata_o,
  output logic             sum_tvalid_o,
  input  logic             sum_tready_i
);

  localparam int unsigned SUM_W = sum_width(WIDTH);

  count_e           count_q, count_d;
  logic [SUM_W-1:0] buf0_q, buf0_d;
  logic [SUM_W-1:0] buf1_q, buf1_d;
  logic [SUM_W-1:0] sum;
  logic             full;
  logic             accept;
  logic             pop;

  adder_comb #(
    .WIDTH (WIDTH)
  ) u_adder_comb (
    .op_a (data1_tdata_i),
    .op_b (data2_tdata_i),
    .sum  (sum)
  );

  // Full comes straight from the count register, keeping sum_tready_i out
  // of the input ready paths. Readies are forced low during reset.
  assign full           = (count_q == CNT_FULL);
  assign data1_tready_o = data2_tvalid_i & ~full & ~rst_i;
  assign data2_tready_o = data1_tvalid_i & ~full & ~rst_i;
  assign accept         = data1_tvalid_i & data2_tvalid_i & ~full & ~rst_i;

  assign sum_tvalid_o = (count_q != CNT_EMPTY);
  assign sum_tdata_o  = buf0_q;
  assign pop          = sum_tvalid_o & sum_tready_i;

  // Occupancy and buffer update: next state of count, head and tail.
  always_comb begin
    count_d = count_q;
    buf0_d  = buf0_q;
    buf1_d  = buf1_q;
    case (count_q)
      CNT_EMPTY: begin
        if (accept) begin
          count_d = CNT_ONE;
          buf0_d  = sum;
        end
      end
      CNT_ONE: begin
        if (accept && pop) begin
          buf0_d = sum;
        end else if (accept) begin
          count_d = CNT_FULL;
          buf1_d  = sum;
        end else if (pop) begin
          count_d = CNT_EMPTY;
        end
      end
      CNT_FULL: begin
        if (pop) begin
          count_d = CNT_ONE;
          buf0_d  = buf1_q;
        end
      end
      default: begin
        count_d = CNT_EMPTY;
      end
    endcase
  end

  // State registers with synchronous reset that discards buffered sums.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= CNT_EMPTY;
      buf0_q  <= '0;
      buf1_q  <= '0;
    end else begin
      count_q <= count_d;
      buf0_q  <= buf0_d;
      buf1_q  <= buf1_d;
    end
  end

endmodule

// File: tb/tb_adder_axis.sv
// Self-checking bench for adder_axis: directed scenarios plus random
// streaming checked against a queue-based model of the output buffer.
module tb_adder_axis;

  localparam int unsigned W = 4;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [W-1:0] data1_tdata_i;
  logic         data1_tvalid_i;
  logic         data1_tready_o;
  logic [W-1:0] data2_tdata_i;
  logic         data2_tvalid_i;
  logic         data2_tready_o;
  logic [W:0]   sum_tdata_o;
  logic         sum_tvalid_o;
  logic         sum_tready_i;

  int checks = 0;
  int errors = 0;

  int q[$];
  int acc_cnt  = 0;
  int pop_cnt  = 0;
  bit acc_seen = 1'b0;
  bit prev_hold = 1'b0;
  logic [W:0] prev_data = '0;

  adder_axis #(.WIDTH(W)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .data1_tdata_i  (data1_tdata_i),
    .data1_tvalid_i (data1_tvalid_i),
    .data1_tready_o (data1_tready_o),
    .data2_tdata_i  (data2_tdata_i),
    .data2_tvalid_i (data2_tvalid_i),
    .data2_tready_o (data2_tready_o),
    .sum_tdata_o    (sum_tdata_o),
    .sum_tvalid_o   (sum_tvalid_o),
    .sum_tready_i   (sum_tready_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic smp();
    @(negedge clk_i);
    #1;
  endtask

  // Reference model: the buffer is a FIFO of pending sums; readiness,
  // validity and head data follow from its size alone.
  always @(negedge clk_i) begin
    acc_seen = 1'b0;
    if (rst_i) begin
      check("rst_rdy1", data1_tready_o, 0);
      check("rst_rdy2", data2_tready_o, 0);
      q.delete();
      prev_hold = 1'b0;
    end else begin
      check("rdy1", data1_tready_o, (data2_tvalid_i && q.size() < 2) ? 1 : 0);
      check("rdy2", data2_tready_o, (data1_tvalid_i && q.size() < 2) ? 1 : 0);
      check("valid", sum_tvalid_o, (q.size() != 0) ? 1 : 0);
      if (q.size() != 0) check("data", sum_tdata_o, q[0]);
      if (prev_hold) check("stable", sum_tdata_o, prev_data);
      if (sum_tvalid_o && sum_tready_i && q.size() != 0) begin
        void'(q.pop_front());
        pop_cnt++;
      end
      if (data1_tvalid_i && data1_tready_o && data2_tvalid_i && data2_tready_o) begin
        q.push_back(int'(data1_tdata_i) + int'(data2_tdata_i));
        acc_cnt++;
        acc_seen = 1'b1;
      end
      prev_hold = sum_tvalid_o && !sum_tready_i;
      prev_data = sum_tdata_o;
    end
  end

  initial begin
    int a0;
    int k;
    int target;
    int budget;

    rst_i = 1'b1;
    data1_tdata_i = '0; data1_tvalid_i = 1'b0;
    data2_tdata_i = '0; data2_tvalid_i = 1'b0;
    sum_tready_i = 1'b0;
    repeat (3) cyc();
    smp();
    check("reset_valid", sum_tvalid_o, 0);
    check("reset_data", sum_tdata_o, 0);
    cyc();
    rst_i = 1'b0;

    // Single pair 3 + 5
    sum_tready_i = 1'b1;
    data1_tdata_i = 4'd3; data2_tdata_i = 4'd5;
    data1_tvalid_i = 1'b1; data2_tvalid_i = 1'b1;
    cyc();
    data1_tvalid_i = 1'b0; data2_tvalid_i = 1'b0;
    smp();
    check("single_valid", sum_tvalid_o, 1);
    check("single_data", sum_tdata_o, 8);
    cyc();
    smp();
    check("single_len", sum_tvalid_o, 0);
    cyc();

    // Max operands then zero
    data1_tdata_i = 4'd15; data2_tdata_i = 4'd15;
    data1_tvalid_i = 1'b1; data2_tvalid_i = 1'b1;
    cyc();
    data1_tdata_i = 4'd0; data2_tdata_i = 4'd0;
    smp();
    check("max_data", sum_tdata_o, 30);
    check("max_carry", sum_tdata_o[W], 1);
    cyc();
    data1_tvalid_i = 1'b0; data2_tvalid_i = 1'b0;
    smp();
    check("zero_valid", sum_tvalid_o, 1);
    check("zero_data", sum_tdata_o, 0);
    check("zero_carry", sum_tdata_o[W], 0);
    cyc();
    cyc();

    // Skewed valids: data1 waits 3 cycles for data2
    a0 = acc_cnt;
    data1_tdata_i = 4'd6; data2_tdata_i = 4'd4;
    data1_tvalid_i = 1'b1; data2_tvalid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      smp();
      check("skew_rdy1", data1_tready_o, 0);
      cyc();
    end
    check("skew_noacc", acc_cnt, a0);
    data2_tvalid_i = 1'b1;
    smp();
    check("skew_rdy1_up", data1_tready_o, 1);
    cyc();
    data1_tvalid_i = 1'b0; data2_tvalid_i = 1'b0;
    smp();
    check("skew_valid", sum_tvalid_o, 1);
    check("skew_data", sum_tdata_o, 10);
    check("skew_one", acc_cnt, a0 + 1);
    cyc();
    cyc();

    // Backpressure with a continuous stream k+k
    sum_tready_i = 1'b0;
    a0 = acc_cnt;
    k = 1;
    data1_tdata_i = W'(k); data2_tdata_i = W'(k);
    data1_tvalid_i = 1'b1; data2_tvalid_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (acc_seen) begin
        k++;
        data1_tdata_i = W'(k); data2_tdata_i = W'(k);
      end
    end
    smp();
    check("bp_accepted", acc_cnt - a0, 2);
    check("bp_rdy1", data1_tready_o, 0);
    check("bp_rdy2", data2_tready_o, 0);
    check("bp_hold", sum_tdata_o, 2);
    cyc();
    sum_tready_i = 1'b1;
    for (int m = 1; m <= 6; m++) begin
      smp();
      check("bp_seq_valid", sum_tvalid_o, 1);
      check("bp_seq_data", sum_tdata_o, 2 * m);
      cyc();
      if (acc_seen) begin
        k++;
        data1_tdata_i = W'(k); data2_tdata_i = W'(k);
      end
    end
    data1_tvalid_i = 1'b0; data2_tvalid_i = 1'b0;
    repeat (4) cyc();

    // Reset while FULL
    sum_tready_i = 1'b0;
    data1_tdata_i = 4'd1; data2_tdata_i = 4'd2;
    data1_tvalid_i = 1'b1; data2_tvalid_i = 1'b1;
    cyc();
    data1_tdata_i = 4'd3; data2_tdata_i = 4'd4;
    cyc();
    smp();
    check("prerst_full", data1_tready_o, 0);
    cyc();
    rst_i = 1'b1;
    cyc();
    rst_i = 1'b0;
    data1_tvalid_i = 1'b0; data2_tvalid_i = 1'b0;
    smp();
    check("postrst_valid", sum_tvalid_o, 0);
    check("postrst_data", sum_tdata_o, 0);
    cyc();
    sum_tready_i = 1'b1;
    data1_tdata_i = 4'd7; data2_tdata_i = 4'd9;
    data1_tvalid_i = 1'b1; data2_tvalid_i = 1'b1;
    cyc();
    data1_tvalid_i = 1'b0; data2_tvalid_i = 1'b0;
    smp();
    check("postrst_sum_valid", sum_tvalid_o, 1);
    check("postrst_sum", sum_tdata_o, 16);
    cyc();
    cyc();

    // Random streaming, 1000 sums
    target = pop_cnt + 1000;
    budget = 0;
    while (pop_cnt < target && budget < 20000) begin
      if (acc_seen) begin
        data1_tvalid_i = 1'b0;
        data2_tvalid_i = 1'b0;
      end
      if (!data1_tvalid_i && ($urandom % 3) != 0) begin
        data1_tvalid_i = 1'b1;
        data1_tdata_i  = W'($urandom);
      end
      if (!data2_tvalid_i && ($urandom % 3) != 0) begin
        data2_tvalid_i = 1'b1;
        data2_tdata_i  = W'($urandom);
      end
      sum_tready_i = (($urandom % 4) != 0);
      cyc();
      budget++;
    end
    check("stream_done", (pop_cnt >= target) ? 1 : 0, 1);
    data1_tvalid_i = 1'b0; data2_tvalid_i = 1'b0;
    sum_tready_i = 1'b1;
    repeat (4) cyc();
    smp();
    check("drain_empty", q.size(), 0);
    check("drain_valid", sum_tvalid_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
